// File: rtl/octal_conv_sched_if.sv
// Bus bundle for octal_conv_sched: two requesters share one binary->octal
// converter.
//   master (requester side): drives req, dec0, dec1; observes the rest.
//   slave  (converter side): observes req/dec0/dec1; drives gnt, ack, busy,
//                            done, done_id, octal.
//   req[1:0]  per-requester request level
//   dec0/dec1 W-bit operands, held while the matching req bit is high
//   gnt[1:0]  one-hot converter owner, 0 when idle
//   ack[1:0]  one-cycle completion pulse to the owner
//   busy      converter working (CONV or DONE)
//   done      one-cycle result-valid pulse
//   done_id   requester whose result is on octal
//   octal     digit-packed result, nibble k = octal digit k
interface octal_conv_sched_if #(
  parameter int W = 16
);
  localparam int D  = (W + 2) / 3;
  localparam int OW = 4 * D;

  logic [1:0]    req;
  logic [W-1:0]  dec0;
  logic [W-1:0]  dec1;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic          busy;
  logic          done;
  logic          done_id;
  logic [OW-1:0] octal;

  modport master (
    output req, dec0, dec1,
    input  gnt, ack, busy, done, done_id, octal
  );

  modport slave (
    input  req, dec0, dec1,
    output gnt, ack, busy, done, done_id, octal
  );
endinterface

// File: rtl/octal_conv_sched.sv
// Shared binary->octal converter with a two-requester round-robin arbiter.
// An accepted operand is converted one octal digit per cycle (LSD first);
// the packed result is published on entry to DONE and held until the next
// DONE.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  octal_conv_sched_if.slave (req/dec0/dec1 in; gnt/ack/busy/done/
//        done_id/octal out)
module octal_conv_sched #(
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst,
  octal_conv_sched_if.slave  bus
);

  localparam int D  = (W + 2) / 3;
  localparam int NW = 3 * D;
  localparam int OW = 4 * D;
  localparam int KW = (D > 1) ? $clog2(D + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [NW-1:0] r_num;
  logic [NW-1:0] w_num_shift;
  logic [KW-1:0] r_k;
  logic [OW-1:0] r_work;
  logic [OW-1:0] w_work_nxt;
  logic [OW-1:0] r_octal;
  logic          r_owner;
  logic          r_rr;
  logic          r_done_id;
  logic          w_pick;
  logic          w_accept;
  logic          w_conv_last;
  logic [W-1:0]  w_operand;
  logic [1:0]    w_owner_oh;

  // r_rr holds the requester served last; a tie goes to the other one.
  always_comb begin
    w_pick = 1'b0;
    case (bus.req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_rr;
      default: w_pick = 1'b0;
    endcase
  end

  assign w_accept    = (r_state == S_IDLE) && (bus.req != 2'b00);
  assign w_operand   = w_pick ? bus.dec1 : bus.dec0;
  assign w_num_shift = r_num >> 3;

  // Current digit lands in nibble r_k; all other nibbles keep their value.
  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < D; k++) begin
      if (r_k == KW'(k)) begin
        w_work_nxt[4*k +: 4] = {1'b0, r_num[2:0]};
      end
    end
  end

  // Stop once no significant digits remain, or the last digit is written.
  assign w_conv_last = (w_num_shift == '0) || (r_k == KW'(D - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CONV;
      S_CONV:  if (w_conv_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control and published-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= 1'b0;
      r_rr      <= 1'b1;
      r_octal   <= '0;
      r_done_id <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner <= w_pick;
      end
      if ((r_state == S_CONV) && w_conv_last) begin
        r_octal   <= w_work_nxt;
        r_done_id <= r_owner;
      end
      if (r_state == S_DONE) begin
        r_rr <= r_owner;
      end
    end
  end

  // Conversion datapath; the captured operand isolates the conversion from
  // later operand changes.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_num  <= NW'(w_operand);
      r_work <= '0;
      r_k    <= '0;
    end else if (r_state == S_CONV) begin
      r_num  <= w_num_shift;
      r_work <= w_work_nxt;
      r_k    <= r_k + 1'b1;
    end
  end

  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.gnt     = bus.busy ? w_owner_oh : 2'b00;
  assign bus.ack     = bus.done ? w_owner_oh : 2'b00;
  assign bus.done_id = r_done_id;
  assign bus.octal   = r_octal;

endmodule

// File: tb/tb_octal_conv_sched.sv
module tb_octal_conv_sched;
  localparam int W  = 16;
  localparam int D  = (W + 2) / 3;
  localparam int OW = 4 * D;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  octal_conv_sched_if #(.W(W)) bus ();

  octal_conv_sched #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [W-1:0]  val;
    logic [OW-1:0] oct;
    int            nconv;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: octal digits by repeated division; cycle count is the number
  // of significant octal digits (at least one).
  function automatic logic [OW-1:0] model_oct(input longint v);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(v % 8);
      v = v / 8;
    end
    return r;
  endfunction

  function automatic int model_n(input longint v);
    int n;
    if (v == 0) return 1;
    n = 0;
    while (v > 0) begin
      v = v / 8;
      n++;
    end
    return n;
  endfunction

  // Raise req[id] with operand val, wait (bounded) for done, check result and
  // latency, drop req[id], then check the following IDLE cycle.
  task automatic do_txn(input int id, input logic [W-1:0] val,
                        input logic [OW-1:0] exp_oct, input int exp_nconv,
                        input bit mutate, input string nm);
    int   got_n;
    logic [1:0] oh;
    oh = (id == 1) ? 2'b10 : 2'b01;
    if (id == 1) bus.dec1 = val; else bus.dec0 = val;
    bus.req[id] = 1'b1;
    got_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk({nm, ".gnt"}, 64'(bus.gnt), 64'(oh));
        if (mutate) begin
          if (id == 1) bus.dec1 = ~val; else bus.dec0 = ~val;
        end
      end
      if (bus.done) begin
        got_n = n;
        break;
      end
    end
    chk({nm, ".done_seen"}, 64'(got_n != 0), 64'd1);
    if (got_n != 0) begin
      chk({nm, ".latency"}, 64'(got_n), 64'(1 + exp_nconv));
      chk({nm, ".octal"}, 64'(bus.octal), 64'(exp_oct));
      chk({nm, ".done_id"}, 64'(bus.done_id), 64'(id));
      chk({nm, ".ack"}, 64'(bus.ack), 64'(oh));
      chk({nm, ".busy"}, 64'(bus.busy), 64'd1);
    end
    bus.req[id] = 1'b0;
    @(negedge clk);
    chk({nm, ".idle_done"}, 64'(bus.done), 64'd0);
    chk({nm, ".idle_busy"}, 64'(bus.busy), 64'd0);
    chk({nm, ".hold_octal"}, 64'(bus.octal), 64'(exp_oct));
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, ".gnt"}, 64'(bus.gnt), 64'd0);
    chk({nm, ".ack"}, 64'(bus.ack), 64'd0);
    chk({nm, ".busy"}, 64'(bus.busy), 64'd0);
    chk({nm, ".done"}, 64'(bus.done), 64'd0);
    chk({nm, ".done_id"}, 64'(bus.done_id), 64'd0);
    chk({nm, ".octal"}, 64'(bus.octal), 64'd0);
  endtask

  initial begin
    int           id;
    logic [W-1:0] v;
    n_chk = 0;
    n_err = 0;

    vecs[0] = '{id: 0, val: 16'd0,     oct: 24'h000000, nconv: 1};
    vecs[1] = '{id: 0, val: 16'hFFFF,  oct: 24'h177777, nconv: 6};
    vecs[2] = '{id: 1, val: 16'd8,     oct: 24'h000010, nconv: 2};
    vecs[3] = '{id: 1, val: 16'd511,   oct: 24'h000777, nconv: 3};
    vecs[4] = '{id: 0, val: 16'd1,     oct: 24'h000001, nconv: 1};
    vecs[5] = '{id: 1, val: 16'h8000,  oct: 24'h100000, nconv: 6};

    rst      = 1'b1;
    bus.req  = 2'b00;
    bus.dec0 = '0;
    bus.dec1 = '0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      do_txn(vecs[i].id, vecs[i].val, vecs[i].oct, vecs[i].nconv, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Tie with requester 1 served last: 0 first, one IDLE, then 1.
    bus.dec0 = 16'd100;
    bus.dec1 = 16'd200;
    bus.req  = 2'b11;
    do_txn(0, 16'd100, 24'h000144, 3, 1'b0, "tie1_r0");
    do_txn(1, 16'd200, 24'h000310, 3, 1'b0, "tie1_r1");
    bus.req = 2'b11;
    do_txn(0, 16'd9, 24'h000011, 2, 1'b0, "tie2_r0");
    do_txn(1, 16'd63, 24'h000077, 2, 1'b0, "tie2_r1");
    // Requester 0 served last: a tie now goes to 1 first.
    do_txn(0, 16'd3, 24'h000003, 1, 1'b0, "solo_r0");
    bus.dec0 = 16'd64;
    bus.dec1 = 16'd65;
    bus.req  = 2'b11;
    do_txn(1, 16'd65, 24'h000101, 3, 1'b0, "tie3_r1");
    do_txn(0, 16'd64, 24'h000100, 3, 1'b0, "tie3_r0");

    // Operand changed mid-conversion is ignored; result held through IDLE.
    do_txn(0, 16'd5, 24'h000005, 1, 1'b1, "mutate");
    repeat (3) begin
      @(negedge clk);
      chk("mutate.hold", 64'(bus.octal), 64'h5);
    end

    for (int t = 0; t < 30; t++) begin
      id = int'($urandom_range(0, 1));
      v  = W'($urandom >> $urandom_range(0, 31));
      do_txn(id, v, model_oct(longint'(v)), model_n(longint'(v)),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
    end

    // Reset during the third CONV cycle aborts with no done or ack.
    bus.dec0 = 16'hFFFF;
    bus.req  = 2'b01;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk($sformatf("abort.no_done%0d", n), 64'(bus.done), 64'd0);
    end
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    chk_zero_outputs("abort");
    rst = 1'b0;
    do_txn(0, 16'd7, 24'h000007, 1, 1'b0, "recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/octal_conv_sched.md
OCTAL_CONV_SCHED -- requirements
Module: octal_conv_sched

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning the binary input width; D = ceil(W/3) octal digits (D=6 at default).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port req, input, 2, per-requester conversion request level (bit i = requester i).
REQ-005 The block SHALL have port dec0, input, W, requester 0 operand, held stable while req[0]=1.
REQ-006 The block SHALL have port dec1, input, W, requester 1 operand, held stable while req[1]=1.
REQ-007 The block SHALL have port gnt, output, 2, one-hot owner of the shared converter, 0 when idle.
REQ-008 The block SHALL have port ack, output, 2, one-cycle completion pulse to the owner.
REQ-009 The block SHALL have port busy, output, 1, high in CONV and DONE.
REQ-010 The block SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-011 The block SHALL have port done_id, output, 1, index of the requester whose result is presented.
REQ-012 The block SHALL have port octal, output, 4*D, digit-packed result: nibble k = octal digit k (LSD at bits 3:0), each nibble 0..7.

Function
REQ-013 The FSM SHALL have states IDLE, CONV, DONE; reset state IDLE.
REQ-014 In IDLE with req!=0 the block SHALL select the owner: a single requester wins outright; if both request, the one not served last wins (rr pointer).
REQ-015 On acceptance the block SHALL capture the owner's operand into num, clear the work result, set digit index k=0, set gnt one-hot, and enter CONV on the next edge.
REQ-016 Each CONV cycle SHALL write nibble k = {0,num[2:0]}, shift num right by 3, increment k.
REQ-017 CONV SHALL exit to DONE when the shifted num is zero or k reaches D-1, so an operand of value 0 takes exactly 1 CONV cycle and value v>0 takes ceil(bits(v)/3) cycles.
REQ-018 Nibbles not written in a conversion SHALL be 0.
REQ-019 DONE SHALL last exactly one cycle: done=1, ack[owner]=1, done_id=owner, octal=final result, rr pointer updated to owner; next state IDLE.
REQ-020 octal and done_id SHALL update only on entry to DONE and hold until the next DONE.
REQ-021 Total latency SHALL be 1 (accept) + N (CONV) cycles from the edge sampling req to the edge where done is visible; no request is sampled in CONV or DONE.
REQ-022 A requester SHALL deassert req on the edge where it samples ack; req still high in the following IDLE cycle is a new request.
REQ-023 Requests arriving in CONV/DONE SHALL wait without loss; back-to-back service SHALL insert exactly one IDLE cycle between DONE and the next CONV.
REQ-024 Operand change while granted SHALL not affect the in-flight conversion (captured copy used).

Reset
REQ-025 rst=1 SHALL force next state IDLE, gnt=0, ack=0, busy=0, done=0, done_id=0, octal=0, rr pointer favouring requester 0 on the first tie.
REQ-026 rst asserted mid-CONV or in DONE SHALL abort the conversion with no ack or done issued, overriding all other inputs.

Verification
REQ-027 req=01, dec0=0 -> 1 CONV cycle, done with octal=0x000000, done_id=0, ack=01.
REQ-028 req=01, dec0=16'hFFFF -> 6 CONV cycles, octal=0x177777, ack=01 at cycle 7 after sampling.
REQ-029 req=10, dec1=8 -> 2 CONV cycles, octal=0x000010, done_id=1; then dec1=511 -> octal=0x000777 after 3 CONV cycles.
REQ-030 req=11 from reset, dec0=100, dec1=200 -> first served 0 (octal=0x000144), one IDLE, then 1 (octal=0x000310); repeat req=11 -> requester 0 served before 1 again only after 1 was served last.
REQ-031 req=01, dec0=65535, rst pulsed at 3rd CONV cycle -> no done/ack, all outputs 0 next cycle, new req=01 dec0=7 -> octal=0x000007 after 1 CONV cycle.
REQ-032 req=01 with dec0 changed 5->6 during CONV -> octal=0x000005; octal holds 0x000005 through subsequent IDLE cycles.
